pm_loader: RTL and testbench
============================

// Module: pm_loader
// PURPOSE
//  Boot stage directly upstream of the micro core: accepts a byte stream (length, instructions,
//  checksum), writes the instructions into program memory starting at address 0, and holds the
//  core in reset until a verified image is present. Drives the core's reset input and the
//  program-memory write port; the core fetches only after micro_reset deasserts.
// PARAMETERS
//  ADDR_W        8     program memory address width (image length 1..2**ADDR_W)
//  DATA_W        8     instruction width
//  TIMEOUT       1000  max cycles between accepted bytes while loading; 0 disables timeout
//  HOLD_CYCLES   2     cycles micro_reset stays high after a good checksum (covers core's reset sync flop)
//  BOOT_ON_RESET 1     1: enter LEN after reset; 0: enter RUN after reset (keep existing memory image)
// PORTS
//  clk          in   1       system clock, all state updates on rising edge
//  sync_reset   in   1       synchronous active-high reset
//  load_req     in   1       1-cycle pulse: start or restart a load
//  in_valid     in   1       input byte valid
//  in_data      in   DATA_W  input byte
//  in_ready     out  1       loader accepts in_data this cycle (transfer = in_valid & in_ready)
//  pm_wr_addr   out  ADDR_W  program memory write address
//  pm_wr_data   out  DATA_W  program memory write data
//  pm_wren      out  1       program memory write enable, 1-cycle pulse per instruction
//  micro_reset  out  1       reset to micro core; high while not in RUN
//  done         out  1       image loaded and verified; high only in RUN
//  err          out  1       checksum mismatch or timeout; high only in ERROR
//  state        out  3       current state encoding (debug/observation)
// BEHAVIOUR
//  Reset: state=LEN (BOOT_ON_RESET=1) else RUN; micro_reset=1 on the cycle after reset if LEN,
//   pm_wren=0, pm_wr_addr=0, pm_wr_data=0, done=0, err=0, count=0, csum=0, timer=0.
//  in_ready is combinational: 1 in LEN, DATA, CSUM; 0 otherwise. All other outputs registered.
//  LEN: on transfer, len=in_data (0 means 2**ADDR_W), addr=0, csum=0 -> DATA.
//  DATA: on transfer, next cycle pm_wren=1, pm_wr_addr=addr, pm_wr_data=in_data; csum+=in_data
//   (mod 2**DATA_W); addr++; when the len-th byte transfers -> CSUM. Latency in byte -> write: 1 cycle.
//  CSUM: on transfer, in_data==csum -> HOLD, else -> ERROR. Checksum byte is never written to memory.
//  HOLD: micro_reset=1, counts HOLD_CYCLES cycles -> RUN. HOLD_CYCLES=0 goes straight to RUN.
//  RUN: micro_reset=0, done=1. load_req -> LEN; micro_reset=1 from next cycle.
//  ERROR: micro_reset=1, err=1, in_ready=0; stays until load_req -> LEN (err clears next cycle).
//  Timeout: timer clears on every transfer and on entry to LEN; increments each cycle in
//   LEN/DATA/CSUM without a transfer; reaching TIMEOUT -> ERROR.
//  load_req in any state -> LEN; it beats a simultaneous transfer (byte discarded, no write) and a
//   simultaneous timeout. Partial images are not erased; core stays in reset.
//  Address wrap: len=2**ADDR_W writes 0..2**ADDR_W-1; addr wraps to 0 only as DATA exits.
//  pm_wren never asserts outside the cycle after a DATA transfer; micro_reset is high whenever
//   pm_wren is high.
//  sync_reset mid-load: immediate return to reset values; any pending write is dropped.
// STRUCTURE
//  Shared package: state encodings (LEN=0, DATA=1, CSUM=2, HOLD=3, RUN=4, ERROR=5), default
//   TIMEOUT and HOLD_CYCLES constants.
//  One sub-module: pm_loader_timer (clear, enable, terminal-count compare, TIMEOUT=0 disable).
//  FSM, byte counter, address/checksum registers and write-port registers stay in pm_loader.
//  Top level muxes program memory address between pm_wr_addr (micro_reset=1) and core pm_address.
// TESTING
//  Good image: stream 03,12,34,56,9C -> writes 12@0,34@1,56@2; done=1 and micro_reset=0 exactly
//   HOLD_CYCLES+1 cycles after the 9C transfer; err=0.
//  Bad checksum: 02,AA,BB,00 -> err=1, micro_reset stays 1, no further writes; load_req then good
//   image -> err=0, done=1.
//  Timeout: 02,AA then in_valid=0 for TIMEOUT cycles -> ERROR on that cycle, exactly one write.
//  Backpressure/gaps: random in_valid gaps < TIMEOUT -> identical writes and done as gap-free run.
//  Full length: len byte 00, 256 bytes i=0..255, checksum 80 -> 256 writes, last addr FF, done=1.
//  Restart priority: load_req on same cycle as a DATA transfer -> no write for that byte, state=LEN;
//   sync_reset mid-DATA -> reset values next cycle, pm_wren=0.

Source files
------------

// File: rtl/pm_loader_pkg.sv
// Shared types and defaults for the program-memory boot loader.
// State encodings are visible on the debug state port, so their values are fixed.
package pm_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN   = 3'd0,
    ST_DATA  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam int DEF_TIMEOUT     = 1000;
  localparam int DEF_HOLD_CYCLES = 2;

  function automatic logic is_loading(state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/pm_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// The loader takes the slave side; the byte source and memory sit on the master side.
interface pm_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] pm_wr_addr;
  logic [DATA_W-1:0] pm_wr_data;
  logic              pm_wren;

  modport master (
    output in_valid, in_data,
    input  in_ready, pm_wr_addr, pm_wr_data, pm_wren
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, pm_wr_addr, pm_wr_data, pm_wren
  );
endinterface

// File: rtl/pm_loader_timer.sv
// Inter-byte idle timer: counts idle loading cycles, flags the cycle that reaches TIMEOUT.
// TIMEOUT=0 disables the terminal-count compare entirely.
module pm_loader_timer
  import pm_loader_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] count;
  logic          tc;

  generate
    if (TIMEOUT == 0) begin : g_off
      assign tc = 1'b0;
    end else begin : g_on
      assign tc = (count == TW'(TIMEOUT - 1));
    end
  endgenerate

  assign expire = enable & tc;

  always_ff @(posedge clk) begin
    if (sync_reset || clear) begin
      count <= '0;
    end else if (enable && !tc) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/pm_loader.sv
// Boot loader: streams length/instructions/checksum into program memory and holds
// the micro core in reset until a verified image has been written.
//
//   state  | meaning
//   LEN    | waiting for image length byte (0 = full memory)
//   DATA   | writing instruction bytes from address 0 upward
//   CSUM   | waiting for checksum byte
//   HOLD   | checksum good, keep core in reset a few more cycles
//   RUN    | core released, image valid
//   ERROR  | bad checksum or timeout, waits for load_req
module pm_loader
  import pm_loader_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int BOOT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] core_pm_addr,
  output logic [ADDR_W-1:0] pm_addr,
  pm_loader_if.slave        bus,
  output logic              micro_reset,
  output logic              done,
  output logic              err,
  output logic [2:0]        state
);

  localparam int CNT_W     = ADDR_W + 1;
  localparam int HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int HOLD_W    = (HOLD_LOAD < 2) ? 1 : $clog2(HOLD_LOAD + 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  len_in;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] csum_q;
  logic [HOLD_W-1:0] hold_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              wren_q;
  logic              micro_reset_q, done_q, err_q;
  logic              in_ready, xfer, timeout;

  assign in_ready = is_loading(state_q);
  assign xfer     = bus.in_valid & in_ready;
  assign len_in   = CNT_W'(bus.in_data);

  pm_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk        (clk),
    .sync_reset (sync_reset),
    .clear      (load_req | xfer | ~in_ready),
    .enable     (in_ready & ~xfer),
    .expire     (timeout)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= (BOOT_ON_RESET != 0) ? ST_LEN : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // load_req outranks every other event, including a same-cycle transfer or timeout
  always_comb begin
    state_d = state_q;
    if (load_req) begin
      state_d = ST_LEN;
    end else begin
      case (state_q)
        ST_LEN: begin
          if (timeout)   state_d = ST_ERROR;
          else if (xfer) state_d = ST_DATA;
        end
        ST_DATA: begin
          if (timeout)                                state_d = ST_ERROR;
          else if (xfer && (count_q == CNT_W'(1)))    state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (timeout) begin
            state_d = ST_ERROR;
          end else if (xfer) begin
            if (bus.in_data != csum_q) state_d = ST_ERROR;
            else if (HOLD_CYCLES == 0) state_d = ST_RUN;
            else                       state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (hold_q == '0) state_d = ST_RUN;
        end
        ST_RUN, ST_ERROR: state_d = state_q;
        default:          state_d = ST_LEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      count_q       <= '0;
      addr_q        <= '0;
      csum_q        <= '0;
      hold_q        <= HOLD_W'(HOLD_LOAD);
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wren_q        <= 1'b0;
      micro_reset_q <= (BOOT_ON_RESET != 0);
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      wren_q        <= 1'b0;
      micro_reset_q <= (state_d != ST_RUN);
      done_q        <= (state_d == ST_RUN);
      err_q         <= (state_d == ST_ERROR);
      hold_q        <= (state_q == ST_HOLD) ? hold_q - HOLD_W'(1) : HOLD_W'(HOLD_LOAD);
      if (xfer && !load_req) begin
        case (state_q)
          ST_LEN: begin
            count_q <= (len_in == '0) ? CNT_W'(1 << ADDR_W) : len_in;
            addr_q  <= '0;
            csum_q  <= '0;
          end
          ST_DATA: begin
            wren_q    <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= bus.in_data;
            csum_q    <= csum_q + bus.in_data;
            addr_q    <= addr_q + ADDR_W'(1);
            count_q   <= count_q - CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.pm_wr_addr = wr_addr_q;
  assign bus.pm_wr_data = wr_data_q;
  assign bus.pm_wren    = wren_q;
  assign micro_reset    = micro_reset_q;
  assign done           = done_q;
  assign err            = err_q;
  assign state          = state_q;
  // the loader owns the memory address whenever the core is held in reset
  assign pm_addr        = micro_reset_q ? wr_addr_q : core_pm_addr;

endmodule

// File: tb/tb_pm_loader.sv
// Directed and randomized bench for pm_loader; expected writes and outcomes come from a
// byte-list model of the boot image (writes = image[i] at i, checksum = sum mod 256).
module tb_pm_loader;
  import pm_loader_pkg::*;

  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int TMO  = 1000;
  localparam int HOLD = 2;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          load_req;
  logic [AW-1:0] core_pm_addr;
  logic [AW-1:0] pm_addr;
  logic          micro_reset, done, err;
  logic [2:0]    state;

  pm_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  pm_loader #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .HOLD_CYCLES(HOLD), .BOOT_ON_RESET(1)
  ) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .load_req     (load_req),
    .core_pm_addr (core_pm_addr),
    .pm_addr      (pm_addr),
    .bus          (bus),
    .micro_reset  (micro_reset),
    .done         (done),
    .err          (err),
    .state        (state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] wq[$];
  logic [15:0] exp_q[$];
  logic [7:0]  img[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (bus.pm_wren === 1'b1) begin
      wq.push_back({bus.pm_wr_addr, bus.pm_wr_data});
      check("wren_implies_micro_reset", micro_reset, 1);
    end
  end

  function automatic logic [7:0] model_csum();
    int sum = 0;
    foreach (img[i]) sum += img[i];
    return 8'(sum % 256);
  endfunction

  function automatic void model_writes();
    exp_q.delete();
    foreach (img[i]) exp_q.push_back({8'(i), img[i]});
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    bit sent = 1'b0;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      tick(1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 20 && !sent; k++) begin
      sent = bus.in_ready;
      tick(1);
    end
    bus.in_valid = 1'b0;
    check("byte_accepted", sent, 1);
  endtask

  task automatic run_image(input logic [7:0] ck, input int max_gap);
    send_byte(8'(img.size()), max_gap);
    foreach (img[i]) send_byte(img[i], max_gap);
    send_byte(ck, max_gap);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick(1);
    load_req = 1'b0;
  endtask

  task automatic rand_image(input int len);
    img.delete();
    repeat (len) img.push_back(8'($urandom));
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_count"}, wq.size(), exp_q.size());
    for (int i = 0; i < wq.size() && i < exp_q.size(); i++) check(tag, wq[i], exp_q[i]);
  endtask

  // called right after the checksum transfer edge
  task automatic check_done_timing();
    for (int k = 0; k < HOLD; k++) begin
      check("done_early", done, 0);
      check("ureset_hold", micro_reset, 1);
      tick(1);
    end
    check("done", done, 1);
    check("ureset_run", micro_reset, 0);
    check("err_good", err, 0);
    check("state_run", state, ST_RUN);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  ck;
    logic [15:0] last;
    bit          bad;

    sync_reset   = 1'b1;
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    core_pm_addr = '0;
    tick(1);
    check("rst_state", state, ST_LEN);
    check("rst_micro_reset", micro_reset, 1);
    check("rst_wren", bus.pm_wren, 0);
    check("rst_wr_addr", bus.pm_wr_addr, 0);
    check("rst_wr_data", bus.pm_wr_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", bus.in_ready, 1);
    sync_reset = 1'b0;

    // good image straight out of reset
    wq.delete();
    img = {8'h12, 8'h34, 8'h56};
    model_writes();
    run_image(8'h9C, 0);
    check_done_timing();
    compare_writes("good_wr");
    core_pm_addr = 8'($urandom);
    #1;
    check("pm_addr_core", pm_addr, core_pm_addr);

    // bad checksum
    pulse_load();
    check("reload_state", state, ST_LEN);
    check("reload_ureset", micro_reset, 1);
    wq.delete();
    img = {8'hAA, 8'hBB};
    model_writes();
    run_image(8'h00, 0);
    check("bad_err", err, 1);
    check("bad_state", state, ST_ERROR);
    check("bad_ureset", micro_reset, 1);
    check("bad_in_ready", bus.in_ready, 0);
    check("bad_done", done, 0);
    core_pm_addr = 8'($urandom);
    #1;
    last = exp_q[exp_q.size() - 1];
    check("pm_addr_loader", pm_addr, last[15:8]);
    tick(10);
    compare_writes("bad_wr");
    check("bad_err_held", err, 1);

    // recovery
    pulse_load();
    check("err_cleared", err, 0);
    wq.delete();
    rand_image(5);
    model_writes();
    run_image(model_csum(), 0);
    check_done_timing();
    compare_writes("recover_wr");

    // timeout after two bytes
    pulse_load();
    wq.delete();
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    tick(TMO - 1);
    check("tmo_not_yet", state, ST_DATA);
    check("tmo_err_not_yet", err, 0);
    tick(1);
    check("tmo_state", state, ST_ERROR);
    check("tmo_err", err, 1);
    tick(2);
    check("tmo_writes", wq.size(), 1);
    check("tmo_write0", wq[0], {8'h00, 8'hAA});

    // random images with random idle gaps; the last one has a corrupted checksum
    for (int t = 0; t < 5; t++) begin
      pulse_load();
      wq.delete();
      rand_image($urandom_range(1, 24));
      model_writes();
      bad = (t == 4);
      ck  = model_csum() ^ (bad ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      run_image(ck, 6);
      if (bad) begin
        check("gap_bad_err", err, 1);
        check("gap_bad_done", done, 0);
        tick(2);
      end else begin
        check_done_timing();
      end
      compare_writes("gap_wr");
    end

    // full-length image
    pulse_load();
    wq.delete();
    img.delete();
    for (int i = 0; i < 256; i++) img.push_back(8'(i));
    model_writes();
    run_image(8'h80, 0);
    check_done_timing();
    compare_writes("full_wr");
    last = wq[wq.size() - 1];
    check("full_last_addr", last[15:8], 8'hFF);

    // load_req beats a same-cycle data transfer
    pulse_load();
    wq.delete();
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h22;
    load_req     = 1'b1;
    tick(1);
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    check("prio_state", state, ST_LEN);
    check("prio_wren", bus.pm_wren, 0);
    check("prio_ureset", micro_reset, 1);
    tick(2);
    check("prio_writes", wq.size(), 1);
    check("prio_write0", wq[0], {8'h00, 8'h11});
    wq.delete();
    rand_image(3);
    model_writes();
    run_image(model_csum(), 2);
    check_done_timing();
    compare_writes("prio_reload_wr");

    // sync_reset in the middle of DATA
    pulse_load();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    sync_reset   = 1'b1;
    tick(1);
    check("srst_state", state, ST_LEN);
    check("srst_wren", bus.pm_wren, 0);
    check("srst_wr_addr", bus.pm_wr_addr, 0);
    check("srst_wr_data", bus.pm_wr_data, 0);
    check("srst_ureset", micro_reset, 1);
    check("srst_done", done, 0);
    check("srst_err", err, 0);
    sync_reset   = 1'b0;
    bus.in_valid = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
